taxi_qsfp_ctrl: RTL and testbench



---
 rtl/taxi_qsfp_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_taxi_qsfp_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/taxi_qsfp_ctrl.sv
// QSFP28 management controller: presence debounce, ResetL/LPMode/ModSelL sequencing
// and a per-lane receive watchdog that requests a lane reset when a lane stays down.
module taxi_qsfp_ctrl #(
    parameter int LANES           = 4,
    parameter int DEBOUNCE_CYCLES = 125000,
    parameter int RST_CYCLES      = 1250,
    parameter int INIT_CYCLES     = 250000000,
    parameter int LINK_TIMEOUT    = 125000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             qsfp_modprsl,
    input  logic             qsfp_intl,
    output logic             qsfp_modsell,
    output logic             qsfp_resetl,
    output logic             qsfp_lpmode,
    input  logic [LANES-1:0] lane_status,
    output logic [LANES-1:0] lane_rst_req,
    input  logic             ctrl_reset_req,
    input  logic             ctrl_lpmode,
    output logic             status_present,
    output logic             status_ready,
    output logic             status_fault,
    output logic [1:0]       status_state
);
    localparam int STATE_MAX = (RST_CYCLES > INIT_CYCLES) ? RST_CYCLES : INIT_CYCLES;
    localparam int CNT_W     = $clog2(STATE_MAX + 1);
    localparam int LANE_W    = $clog2(LINK_TIMEOUT + 1);
    localparam int DEB_W     = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CNT_W-1:0]  RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  INIT_LAST = CNT_W'(INIT_CYCLES - 1);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LINK_TIMEOUT - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_ABSENT = 2'd0,
        ST_RESET  = 2'd1,
        ST_INIT   = 2'd2,
        ST_READY  = 2'd3
    } state_t;

    logic [1:0]       r_prs_sync;
    logic [1:0]       r_intl_sync;
    logic             r_present;
    logic [DEB_W-1:0] r_deb_cnt;
    logic             w_prs_now;

    // Pins idle high (absent, no interrupt) so reset never looks like a module event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prs_sync  <= 2'b11;
            r_intl_sync <= 2'b11;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge values,
            // which is what turns these two lines into a real two-stage synchronizer.
            r_prs_sync  <= {r_prs_sync[0], qsfp_modprsl};
            r_intl_sync <= {r_intl_sync[0], qsfp_intl};
        end
    end

    assign w_prs_now = ~r_prs_sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_present <= 1'b0;
            r_deb_cnt <= '0;
        end else if (w_prs_now == r_present) begin
            r_deb_cnt <= '0;
        end else if (r_deb_cnt == DEB_LAST) begin
            r_present <= ~r_present;
            r_deb_cnt <= '0;
        end else begin
            r_deb_cnt <= r_deb_cnt + DEB_W'(1);
        end
    end

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_modsell;
    logic             w_resetl;
    logic             w_lpmode;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_ABSENT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it
        // unassigned and no latch is inferred.
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_modsell    = 1'b1;
        w_resetl     = 1'b0;
        w_lpmode     = 1'b1;

        if (!r_present) begin
            w_state_next = ST_ABSENT;
            w_cnt_next   = '0;
        end else if (ctrl_reset_req && (r_state == ST_INIT || r_state == ST_READY)) begin
            w_state_next = ST_RESET;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                ST_ABSENT: begin
                    w_state_next = ST_RESET;
                    w_cnt_next   = '0;
                end
                ST_RESET: begin
                    if (r_cnt == RST_LAST) begin
                        w_state_next = ST_INIT;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
                ST_INIT: begin
                    if (r_cnt == INIT_LAST) begin
                        w_state_next = ST_READY;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end

        case (r_state)
            ST_INIT: w_resetl = 1'b1;
            ST_READY: begin
                w_resetl  = 1'b1;
                w_modsell = 1'b0;
                w_lpmode  = ctrl_lpmode;
            end
            default: ;
        endcase
    end

    logic [LANE_W-1:0] r_lane_cnt [LANES];
    logic [LANES-1:0]  r_lane_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: this counter array is plain flops, not RAM, so resetting it is cheap
            // and required; a RAM-style array would be left unreset instead.
            for (int n = 0; n < LANES; n++) r_lane_cnt[n] <= '0;
            r_lane_req <= '0;
        end else begin
            for (int n = 0; n < LANES; n++) begin
                r_lane_req[n] <= 1'b0;
                if (r_state != ST_READY || lane_status[n]) begin
                    r_lane_cnt[n] <= '0;
                end else if (r_lane_cnt[n] == LANE_LAST) begin
                    r_lane_cnt[n] <= '0;
                    r_lane_req[n] <= 1'b1;
                end else begin
                    r_lane_cnt[n] <= r_lane_cnt[n] + LANE_W'(1);
                end
            end
        end
    end

    logic       r_modsell;
    logic       r_resetl;
    logic       r_lpmode;
    logic       r_stat_present;
    logic       r_stat_ready;
    logic       r_stat_fault;
    logic [1:0] r_stat_state;

    // One register stage between the state register and every pin/status output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_modsell      <= 1'b1;
            r_resetl       <= 1'b0;
            r_lpmode       <= 1'b1;
            r_stat_present <= 1'b0;
            r_stat_ready   <= 1'b0;
            r_stat_fault   <= 1'b0;
            r_stat_state   <= 2'd0;
        end else begin
            r_modsell      <= w_modsell;
            r_resetl       <= w_resetl;
            r_lpmode       <= w_lpmode;
            r_stat_present <= r_present;
            r_stat_ready   <= (r_state == ST_READY);
            r_stat_fault   <= (r_state == ST_READY) && !r_intl_sync[1];
            r_stat_state   <= r_state;
        end
    end

    assign qsfp_modsell   = r_modsell;
    assign qsfp_resetl    = r_resetl;
    assign qsfp_lpmode    = r_lpmode;
    assign lane_rst_req   = r_lane_req;
    assign status_present = r_stat_present;
    assign status_ready   = r_stat_ready;
    assign status_fault   = r_stat_fault;
    assign status_state   = r_stat_state;
endmodule

// File: tb/tb_taxi_qsfp_ctrl.sv
// Scoreboard bench for taxi_qsfp_ctrl: a timeline-based reference model predicts every
// output cycle; a negedge monitor pops and compares.
module tb_taxi_qsfp_ctrl;
    localparam int LANES = 4;
    localparam int DEB   = 3;
    localparam int RSTC  = 4;
    localparam int INITC = 10;
    localparam int LT    = 8;

    localparam int S_ABSENT = 0;
    localparam int S_RESET  = 1;
    localparam int S_INIT   = 2;
    localparam int S_READY  = 3;

    typedef struct packed {
        logic       modsell;
        logic       resetl;
        logic       lpmode;
        logic [3:0] lane_req;
        logic       present;
        logic       ready;
        logic       fault;
        logic [1:0] state;
    } snap_t;

    logic             clk         = 1'b0;
    logic             rst         = 1'b1;
    logic             modprsl     = 1'b0;
    logic             intl        = 1'b1;
    logic [LANES-1:0] lane_status = 4'hf;
    logic             reset_req   = 1'b0;
    logic             lpmode_req  = 1'b0;
    logic             modsell;
    logic             resetl;
    logic             lpmode;
    logic [LANES-1:0] lane_rst_req;
    logic             st_present;
    logic             st_ready;
    logic             st_fault;
    logic [1:0]       st_state;

    int n_compared   = 0;
    int n_mismatched = 0;

    taxi_qsfp_ctrl #(
        .LANES(LANES), .DEBOUNCE_CYCLES(DEB), .RST_CYCLES(RSTC),
        .INIT_CYCLES(INITC), .LINK_TIMEOUT(LT)
    ) dut (
        .clk(clk), .rst(rst),
        .qsfp_modprsl(modprsl), .qsfp_intl(intl),
        .qsfp_modsell(modsell), .qsfp_resetl(resetl), .qsfp_lpmode(lpmode),
        .lane_status(lane_status), .lane_rst_req(lane_rst_req),
        .ctrl_reset_req(reset_req), .ctrl_lpmode(lpmode_req),
        .status_present(st_present), .status_ready(st_ready),
        .status_fault(st_fault), .status_state(st_state)
    );

    always #5 clk = ~clk;

    // Reference model: state is derived from the time elapsed since the sequence started.
    snap_t sb_q[$];
    bit    sb_started = 1'b0;
    int    edge_n, seq_start, run_len, m_state;
    bit    m_active, m_present, run_val;
    bit    m_prs_s0, m_prs_s1, m_intl_s0, m_intl_s1;
    int    down_run [LANES];

    function automatic snap_t reset_snap();
        snap_t s;
        s = '0;
        s.modsell = 1'b1;
        s.lpmode  = 1'b1;
        return s;
    endfunction

    task automatic model_step();
        snap_t            e;
        logic [LANES-1:0] fire;
        int               d;
        if (rst) begin
            m_prs_s0 = 1'b1; m_prs_s1 = 1'b1; m_intl_s0 = 1'b1; m_intl_s1 = 1'b1;
            m_present = 1'b0; run_val = 1'b1; run_len = 0;
            m_active = 1'b0; m_state = S_ABSENT; edge_n = 0; seq_start = 0;
            for (int n = 0; n < LANES; n++) down_run[n] = 0;
            sb_q.delete();
            sb_q.push_back(reset_snap());
            sb_started = 1'b1;
        end else begin
            edge_n++;
            fire = '0;
            for (int n = 0; n < LANES; n++) begin
                if (m_state == S_READY && !lane_status[n]) begin
                    down_run[n]++;
                    fire[n] = (down_run[n] % LT) == 0;
                end else begin
                    down_run[n] = 0;
                end
            end
            e.modsell  = (m_state != S_READY);
            e.resetl   = (m_state == S_INIT || m_state == S_READY);
            e.lpmode   = (m_state == S_READY) ? lpmode_req : 1'b1;
            e.lane_req = fire;
            e.present  = m_present;
            e.ready    = (m_state == S_READY);
            e.fault    = (m_state == S_READY) && !m_intl_s1;
            e.state    = 2'(m_state);

            if (!m_present) m_active = 1'b0;
            else if (!m_active) begin
                m_active  = 1'b1;
                seq_start = edge_n;
            end else if (reset_req && (m_state == S_INIT || m_state == S_READY)) begin
                seq_start = edge_n;
            end
            d = edge_n - seq_start;
            if (!m_active)            m_state = S_ABSENT;
            else if (d < RSTC)         m_state = S_RESET;
            else if (d < RSTC + INITC) m_state = S_INIT;
            else                       m_state = S_READY;

            // Presence flips once DEB consecutive synchronized samples disagree with it.
            if (m_prs_s1 == run_val) run_len++;
            else begin
                run_val = m_prs_s1;
                run_len = 1;
            end
            if ((!run_val) != m_present && run_len >= DEB) m_present = !run_val;

            m_prs_s1  = m_prs_s0;  m_prs_s0  = modprsl;
            m_intl_s1 = m_intl_s0; m_intl_s0 = intl;
            sb_q.push_back(e);
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    task automatic check(input string name, input snap_t act, input snap_t exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s @%0t: got modsell/resetl/lpmode=%b%b%b lane_req=%b present/ready/fault=%b%b%b state=%0d, expected %b%b%b lane_req=%b %b%b%b state=%0d",
                     name, $time, act.modsell, act.resetl, act.lpmode, act.lane_req,
                     act.present, act.ready, act.fault, act.state,
                     exp.modsell, exp.resetl, exp.lpmode, exp.lane_req,
                     exp.present, exp.ready, exp.fault, exp.state);
        end
    endtask

    initial forever begin
        snap_t act;
        @(negedge clk);
        act = {modsell, resetl, lpmode, lane_rst_req, st_present, st_ready, st_fault, st_state};
        if (sb_q.size() != 0) begin
            check("outputs", act, sb_q.pop_front());
        end else if (sb_started) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL scoreboard_empty @%0t: got no prediction, required one per cycle", $time);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset_req();
        reset_req = 1'b1;
        tick(1);
        reset_req = 1'b0;
    endtask

    initial begin
        tick(3);
        rst = 1'b0;

        // Power-up with module present, then random LPMode requests in READY.
        tick(22);
        repeat (6) begin
            lpmode_req = 1'($urandom_range(0, 1));
            tick(1);
        end

        // Short glitch, then a real removal and reinsertion.
        modprsl = 1'b1;
        tick($urandom_range(1, 2));
        modprsl = 1'b0;
        tick(8);
        modprsl = 1'b1;
        tick(10);
        modprsl = 1'b0;
        tick(24);

        // Software reset from READY, second pulse lands in RESET.
        pulse_reset_req();
        tick(2);
        pulse_reset_req();
        tick(22);

        // Lane watchdog: lane 2 held down, then restored one cycle before timeout.
        lane_status = 4'b1011;
        tick(30);
        lane_status = 4'hf;
        tick(2);
        lane_status = 4'b1011;
        tick(LT - 1);
        lane_status = 4'hf;
        tick(4);
        repeat (60) begin
            for (int n = 0; n < LANES; n++)
                if ($urandom_range(0, 5) == 0) lane_status[n] = ~lane_status[n];
            tick(1);
        end
        lane_status = 4'hf;

        // Interrupt asserted during INIT, held into READY.
        pulse_reset_req();
        tick(7);
        intl = 1'b0;
        tick(14);
        intl = 1'b1;
        tick(4);

        // Software reset in the cycle presence falls.
        modprsl = 1'b1;
        tick(2 + DEB);
        pulse_reset_req();
        tick(4);
        modprsl = 1'b0;
        tick(24);

        // Asynchronous reset mid-INIT, then the full sequence again.
        pulse_reset_req();
        tick(7);
        @(posedge clk);
        #3 rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(26);

        // Random mix of every input.
        repeat (400) begin
            if (modprsl) begin
                if ($urandom_range(0, 9) == 0) modprsl = 1'b0;
            end else if ($urandom_range(0, 79) == 0) begin
                modprsl = 1'b1;
            end
            reset_req = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) == 0) lpmode_req = ~lpmode_req;
            if ($urandom_range(0, 14) == 0) intl = ~intl;
            for (int n = 0; n < LANES; n++)
                if ($urandom_range(0, 7) == 0) lane_status[n] = ~lane_status[n];
            tick(1);
        end
        reset_req = 1'b0;
        tick(3);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
